// File: rtl/y86_pkg.sv
// Shared Y86-64 register index constants for decode, pipeline registers and the register file.
package y86_pkg;

    localparam logic [3:0] RRAX  = 4'h0;
    localparam logic [3:0] RRCX  = 4'h1;
    localparam logic [3:0] RRDX  = 4'h2;
    localparam logic [3:0] RRBX  = 4'h3;
    localparam logic [3:0] RRSP  = 4'h4;
    localparam logic [3:0] RRBP  = 4'h5;
    localparam logic [3:0] RRSI  = 4'h6;
    localparam logic [3:0] RRDI  = 4'h7;
    localparam logic [3:0] RR8   = 4'h8;
    localparam logic [3:0] RR9   = 4'h9;
    localparam logic [3:0] RR10  = 4'hA;
    localparam logic [3:0] RR11  = 4'hB;
    localparam logic [3:0] RR12  = 4'hC;
    localparam logic [3:0] RR13  = 4'hD;
    localparam logic [3:0] RR14  = 4'hE;
    localparam logic [3:0] RNONE = 4'hF;

endpackage

// File: rtl/y86_scoreboard.sv
// Per-register pending-write counters, decode stall generation and sticky underflow error.
module y86_scoreboard
    import y86_pkg::*;
#(
    parameter int NREGS  = 15,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] srcA,
    input  logic [ADDR_W-1:0] srcB,
    input  logic [ADDR_W-1:0] dstE,
    input  logic [ADDR_W-1:0] dstM,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_dstE,
    input  logic [ADDR_W-1:0] iss_dstM,
    output logic              stall,
    output logic              err
);
    localparam int unsigned NR = NREGS;
    localparam int unsigned EW = CNT_W + 2;
    localparam logic [EW-1:0] CMAX = EW'((1 << CNT_W) - 1);

    logic [CNT_W-1:0] cnt_q [NREGS];
    logic [CNT_W-1:0] cnt_d [NREGS];
    logic [EW-1:0]    dec   [NREGS];
    logic [EW-1:0]    inc   [NREGS];
    logic [EW-1:0]    post  [NREGS];
    logic             err_q, err_d;
    logic             pend, ovf;

    // post is the count after this cycle's writebacks, saturated at 0 on underflow
    always_comb begin
        err_d = err_q;
        pend  = 1'b0;
        ovf   = 1'b0;
        for (int unsigned r = 0; r < NR; r++) begin
            dec[r] = EW'(dstE == ADDR_W'(r)) + EW'(dstM == ADDR_W'(r));
            inc[r] = iss_valid ? EW'(iss_dstE == ADDR_W'(r)) + EW'(iss_dstM == ADDR_W'(r)) : '0;
            if (dec[r] > EW'(cnt_q[r])) begin
                post[r] = '0;
                err_d   = 1'b1;
            end else begin
                post[r] = EW'(cnt_q[r]) - dec[r];
            end
            if ((post[r] != '0) && ((srcA == ADDR_W'(r)) || (srcB == ADDR_W'(r))))
                pend = 1'b1;
            if ((post[r] + inc[r]) > CMAX)
                ovf = 1'b1;
        end
        stall = pend | ovf;
        for (int unsigned r = 0; r < NR; r++) begin
            cnt_d[r] = stall ? CNT_W'(post[r]) : CNT_W'(post[r] + inc[r]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
            for (int unsigned r = 0; r < NR; r++) cnt_q[r] <= '0;
        end else begin
            err_q <= err_d;
            for (int unsigned r = 0; r < NR; r++) cnt_q[r] <= cnt_d[r];
        end
    end

    assign err = err_q;

endmodule

// File: rtl/y86_regfile_sb.sv
// Y86-64 register file: two forwarding read ports, E/M write ports (M wins), debug port, scoreboard.
module y86_regfile_sb
    import y86_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int NREGS  = 15,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] srcA,
    input  logic [ADDR_W-1:0] srcB,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    input  logic [ADDR_W-1:0] dstE,
    input  logic [ADDR_W-1:0] dstM,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_dstE,
    input  logic [ADDR_W-1:0] iss_dstM,
    output logic              stall,
    output logic              err,
    input  logic [ADDR_W-1:0] dbg_sel,
    output logic [DATA_W-1:0] dbg_val
);
    localparam int unsigned NR = NREGS;

    logic [DATA_W-1:0] regs_q [NREGS];

    // an in-range source that matches a writeback port implies that port is in range too
    always_comb begin
        valA = '0;
        if (32'(srcA) < NR) begin
            if (srcA == dstM)      valA = valM;
            else if (srcA == dstE) valA = valE;
            else                   valA = regs_q[srcA];
        end
    end

    always_comb begin
        valB = '0;
        if (32'(srcB) < NR) begin
            if (srcB == dstM)      valB = valM;
            else if (srcB == dstE) valB = valE;
            else                   valB = regs_q[srcB];
        end
    end

    always_comb begin
        dbg_val = '0;
        if (32'(dbg_sel) < NR) dbg_val = regs_q[dbg_sel];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NR; r++) regs_q[r] <= '0;
        end else begin
            for (int unsigned r = 0; r < NR; r++) begin
                if (dstM == ADDR_W'(r))      regs_q[r] <= valM;
                else if (dstE == ADDR_W'(r)) regs_q[r] <= valE;
            end
        end
    end

    y86_scoreboard #(
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .srcA      (srcA),
        .srcB      (srcB),
        .dstE      (dstE),
        .dstM      (dstM),
        .iss_valid (iss_valid),
        .iss_dstE  (iss_dstE),
        .iss_dstM  (iss_dstM),
        .stall     (stall),
        .err       (err)
    );

endmodule
